// File: rtl/chip_host_bridge.sv
// chip_host_bridge: host-side bridge that serializes cache requests into byte beats
// toward the chip and collects the response beats back for the host.
module chip_host_bridge #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_core,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              resp_err,
    output logic [11:0]       pin_out,
    input  logic [11:0]       pin_in
);
    localparam int NA = ADDR_W / 8;
    localparam int ND = DATA_W / 8;
    localparam int CW = $clog2((ADDR_W > DATA_W ? ADDR_W : DATA_W) / 8) + 1;
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, HDR, ADDR, DATA, WAIT, RESP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [TW-1:0]     wcnt_q, wcnt_d;
    logic              write_q, write_d;
    logic [1:0]        core_q, core_d;
    logic [ADDR_W-1:0] addr_q, addr_d, addr_sh;
    logic [DATA_W-1:0] wdata_q, wdata_d, wdata_sh;
    logic [DATA_W-1:0] rbuf_q, rbuf_d;
    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              resp_err_q, resp_err_d;
    logic [11:0]       pin_out_q, pin_out_d;
    logic              xfer;
    logic              unused_pins;

    assign unused_pins = ^pin_in[9:8];
    assign xfer = pin_out_q[11] && !pin_in[10];

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wcnt_d       = wcnt_q;
        write_d      = write_q;
        core_d       = core_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rbuf_d       = rbuf_q;
        resp_valid_d = resp_valid_q;
        resp_rdata_d = resp_rdata_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            IDLE: if (req_valid && req_ready_q) begin
                state_d = HDR;
                write_d = req_write;
                core_d  = req_core;
                addr_d  = req_addr;
                wdata_d = req_wdata;
            end
            HDR: if (xfer) begin
                state_d = ADDR;
                cnt_d   = '0;
            end
            ADDR: if (xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(NA - 1)) begin
                    state_d = write_q ? DATA : WAIT;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    rbuf_d  = '0;
                end
            end
            DATA: if (xfer) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(ND - 1)) begin
                    state_d = WAIT;
                    cnt_d   = '0;
                    wcnt_d  = '0;
                    rbuf_d  = '0;
                end
            end
            WAIT: begin
                wcnt_d = wcnt_q + 1'b1;
                if (pin_in[11]) begin
                    rbuf_d = (rbuf_q << 8) | DATA_W'(pin_in[7:0]);
                    cnt_d  = cnt_q + 1'b1;
                end
                // A final byte on the timeout edge still wins over the error.
                if (pin_in[11] && (write_q || cnt_q == CW'(ND - 1))) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = write_q ? '0 : rbuf_d;
                    resp_err_d   = write_q && (pin_in[7:0] != 8'h00);
                end else if (wcnt_d == TW'(TIMEOUT)) begin
                    state_d      = RESP;
                    resp_valid_d = 1'b1;
                    resp_rdata_d = '0;
                    resp_err_d   = 1'b1;
                end
            end
            RESP: if (resp_ready) begin
                state_d      = IDLE;
                resp_valid_d = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        addr_sh     = addr_d >> (8 * (NA - 1 - int'(cnt_d)));
        wdata_sh    = wdata_d >> (8 * (ND - 1 - int'(cnt_d)));
        pin_out_d   = state_d == HDR  ? {4'b1100, write_d, core_d, 5'b0} :
                      state_d == ADDR ? {4'b1000, addr_sh[7:0]} :
                      state_d == DATA ? {4'b1000, wdata_sh[7:0]} : 12'h000;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            wcnt_q       <= '0;
            write_q      <= 1'b0;
            core_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            rbuf_q       <= '0;
            req_ready_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= '0;
            resp_err_q   <= 1'b0;
            pin_out_q    <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wcnt_q       <= wcnt_d;
            write_q      <= write_d;
            core_q       <= core_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            rbuf_q       <= rbuf_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_err_q   <= resp_err_d;
            pin_out_q    <= pin_out_d;
        end
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_rdata = resp_rdata_q;
    assign resp_err   = resp_err_q;
    assign pin_out    = pin_out_q;
endmodule

// File: tb/tb_chip_host_bridge.sv
// tb_chip_host_bridge: scoreboard bench; expected beats and responses are queued as
// stimulus is driven and compared when the bridge transfers a beat or a response.
module tb_chip_host_bridge;
    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_core = '0;
    logic [15:0] req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [15:0] resp_rdata;
    logic        resp_err;
    logic [11:0] pin_out;
    logic [11:0] pin_in = '0;

    logic [11:0] exp_beats[$];
    logic [16:0] exp_resp[$];
    int checks = 0;
    int failures = 0;

    chip_host_bridge dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_core(req_core), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err),
        .pin_out(pin_out), .pin_in(pin_in)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    always @(negedge clock) begin
        if (!reset) begin
            if (pin_out[11] && !pin_in[10]) begin
                if (exp_beats.size() == 0) chk("beat_extra", 32'(pin_out), 32'h0);
                else chk("beat", 32'(pin_out), 32'(exp_beats.pop_front()));
            end
            if (resp_valid && resp_ready) begin
                if (exp_resp.size() == 0) chk("resp_extra", 32'(resp_valid), 32'h0);
                else chk("resp", {15'b0, resp_err, resp_rdata}, 32'(exp_resp.pop_front()));
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic w, input logic [1:0] core, input logic [15:0] addr,
                         input logic [15:0] wd);
        logic [11:0] hdr;
        hdr = {4'b1100, w, core, 5'b0};
        for (int i = 0; i < 300 && !req_ready; i++) step();
        chk("req_ready", 32'(req_ready), 32'h1);
        exp_beats.push_back(hdr);
        exp_beats.push_back({4'b1000, addr[15:8]});
        exp_beats.push_back({4'b1000, addr[7:0]});
        if (w) begin
            exp_beats.push_back({4'b1000, wd[15:8]});
            exp_beats.push_back({4'b1000, wd[7:0]});
        end
        req_valid = 1'b1;
        req_write = w;
        req_core  = core;
        req_addr  = addr;
        req_wdata = wd;
        step();
        req_valid = 1'b0;
        chk("hdr_lat", 32'(pin_out), 32'(hdr));
        chk("rdy_drop", 32'(req_ready), 32'h0);
    endtask

    task automatic to_wait();
        for (int i = 0; i < 200 && exp_beats.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        chk("beats_done", exp_beats.size(), 0);
        step();
    endtask

    task automatic reply(input int n, input logic [15:0] bytes);
        for (int i = n - 1; i >= 0; i--) begin
            pin_in = {4'b1000, bytes[8*i +: 8]};
            step();
        end
        pin_in = '0;
    endtask

    task automatic wait_resp();
        for (int i = 0; i < 400 && exp_resp.size() != 0; i++) begin
            @(negedge clock);
            #1;
        end
        chk("resp_done", exp_resp.size(), 0);
        step();
    endtask

    initial begin
        int n;
        #1 reset = 1'b1;
        #2;
        chk("rst_req_ready", 32'(req_ready), 32'h0);
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_rdata", 32'(resp_rdata), 32'h0);
        chk("rst_err", 32'(resp_err), 32'h0);
        chk("rst_pin_out", 32'(pin_out), 32'h0);
        repeat (2) step();
        reset = 1'b0;

        // basic read
        issue(1'b0, 2'd2, 16'h1234, 16'h0);
        exp_resp.push_back({1'b0, 16'hBEEF});
        to_wait();
        chk("wait_pin_out", 32'(pin_out), 32'h0);
        reply(2, 16'hBEEF);
        wait_resp();

        // writes with good and bad status
        issue(1'b1, 2'd1, 16'h00FF, 16'hCAFE);
        exp_resp.push_back({1'b0, 16'h0000});
        to_wait();
        reply(1, 16'h0000);
        wait_resp();
        issue(1'b1, 2'd3, 16'hA5A5, 16'h0102);
        exp_resp.push_back({1'b1, 16'h0000});
        to_wait();
        reply(1, 16'h0003);
        wait_resp();

        // chip busy on the second address beat
        issue(1'b0, 2'd0, 16'h1234, 16'h0);
        exp_resp.push_back({1'b0, 16'h1357});
        for (int i = 0; i < 50 && pin_out !== 12'h834; i++) step();
        chk("bp_beat", 32'(pin_out), 32'h834);
        pin_in[10] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_hold", 32'(pin_out), 32'h834);
        end
        pin_in[10] = 1'b0;
        step();
        chk("bp_next", 32'(pin_out), 32'h0);
        chk("bp_beats_done", exp_beats.size(), 0);
        reply(2, 16'h1357);
        wait_resp();

        // timeout with no response beats
        issue(1'b0, 2'd1, 16'h4321, 16'h0);
        exp_resp.push_back({1'b1, 16'h0000});
        to_wait();
        for (n = 0; n < 400 && !resp_valid; n++) step();
        chk("timeout_cycles", n, 255);
        wait_resp();

        // final byte on the timeout edge counts as valid
        issue(1'b0, 2'd0, 16'h0000, 16'h0);
        exp_resp.push_back({1'b0, 16'hA1B2});
        to_wait();
        pin_in = 12'h8A1;
        step();
        pin_in = '0;
        repeat (253) step();
        pin_in = 12'h8B2;
        step();
        pin_in = '0;
        chk("edge_valid", 32'(resp_valid), 32'h1);
        wait_resp();

        // host stall with stray beats
        resp_ready = 1'b0;
        issue(1'b0, 2'd3, 16'h0F0F, 16'h0);
        exp_resp.push_back({1'b0, 16'h5AA5});
        to_wait();
        reply(2, 16'h5AA5);
        for (int i = 0; i < 20 && !resp_valid; i++) step();
        chk("stall_valid0", 32'(resp_valid), 32'h1);
        for (int i = 0; i < 10; i++) begin
            pin_in = {4'b1000, 8'($urandom_range(0, 255))};
            step();
            chk("stall_data", 32'(resp_rdata), 32'h5AA5);
            chk("stall_err", 32'(resp_err), 32'h0);
            chk("stall_valid", 32'(resp_valid), 32'h1);
            chk("stall_rdy", 32'(req_ready), 32'h0);
        end
        pin_in = '0;
        resp_ready = 1'b1;
        wait_resp();

        // async reset during the data phase
        issue(1'b1, 2'd2, 16'hBEEF, 16'hCAFE);
        for (int i = 0; i < 50 && pin_out !== 12'h8CA; i++) step();
        chk("rst_mid_data", 32'(pin_out), 32'h8CA);
        #1 reset = 1'b1;
        #1;
        chk("arst_pin_out", 32'(pin_out), 32'h0);
        chk("arst_req_ready", 32'(req_ready), 32'h0);
        exp_beats.delete();
        step();
        reset = 1'b0;
        issue(1'b0, 2'd1, 16'h2468, 16'h0);
        exp_resp.push_back({1'b0, 16'hC0DE});
        to_wait();
        reply(2, 16'hC0DE);
        wait_resp();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1);
    end
endmodule
